neuron_mac_seq: RTL
===================

Name: neuron_mac_seq

Overview:
- Sequences the shared 8x8 unsigned multiplier (`deep`) to compute one neuron's dot product over up to N_INPUTS activation/weight pairs.
- Pairs are read from the activation and weight memories, which share one address and have a registered 1-cycle read.
- The block accumulates the products and presents the sum to the downstream activation stage through a valid/ready handshake.
- It owns the only `deep` instance in the tile.

Parameters:
- N_INPUTS, 16, maximum number of terms per dot product.
- ADDR_W, 4, memory address width; must be at least clog2(N_INPUTS).
- LEN_W, 5, width of the len port; must be at least clog2(N_INPUTS+1).
- ACC_W, 24, accumulator width; must be at least 16+clog2(N_INPUTS), so overflow is impossible.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a dot product; sampled only in IDLE.
- len, input, LEN_W, number of terms; sampled with start.
- busy, output, 1, high in every state except IDLE.
- rd_en, output, 1, memory read strobe.
- rd_addr, output, ADDR_W, shared activation/weight address.
- act_data, input, 8, activation read data, valid the cycle after rd_en.
- wt_data, input, 8, weight read data, valid the cycle after rd_en.
- result, output, ACC_W, dot-product sum.
- result_valid, output, 1, result available.
- result_ready, input, 1, downstream accepts result.

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst is synchronous and active-high.
  - On rst, on the following edge: state=IDLE, busy=0, rd_en=0, rd_addr=0, result=0, result_valid=0, accumulator=0, pipeline valid bits=0.
  - Reset mid-operation discards all in-flight reads and products. Memory data arriving afterwards is ignored.
- len handling:
  - len is latched as len_q = min(len, N_INPUTS) on the accepted start.
- State machine: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH on start with len_q>0. The accumulator is cleared on the same edge.
  - IDLE -> DONE on start with len_q==0. result=0.
  - FETCH: rd_en=1 and rd_addr=0,1,...,len_q-1 on consecutive cycles. After address len_q-1 is issued, go to DRAIN.
  - DRAIN: wait until the last product has been accumulated (2 cycles), then go to DONE.
  - DONE: result_valid=1. Go to IDLE on the edge where result_valid && result_ready. busy deasserts the cycle after.
- Datapath pipeline:
  - Stage 1: address/rd_en.
  - Stage 2: act_data and wt_data drive `deep` combinationally; the 16-bit product is registered into prod_q with prod_v.
  - Stage 3: when prod_v, acc <= acc + zero-extended prod_q.
  - No stalls: memories always return data; no bubbles are inserted.
- Latency:
  - start sampled at edge k: rd_en is high in cycles k+1 .. k+len_q.
  - result_valid rises in cycle k+len_q+3 for len_q>0, and in cycle k+1 for len_q==0.
- Handshake:
  - result is driven from the accumulator and is held stable while result_valid && !result_ready.
  - result_valid never drops without an accept.
  - result_ready outside DONE is ignored.
- start rules:
  - start while busy is ignored, including in the cycle of the accept.
  - start is only accepted once the block is back in IDLE.
- Arithmetic is unsigned throughout. Signed/fixed-point support is out of scope for this block.

Decomposition:
- Package nn_pkg holds:
  - typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} mac_state_t;
  - localparams for the default N_INPUTS, ACC_W, and DATA_W=8.
- Sub-module: instantiate the existing `deep` multiplier as the stage-2 datapath.
- No other sub-module. Counter, FSM and accumulator live in neuron_mac_seq.

Test Plan:
- len=4, act={1,2,3,4}, wt={10,20,30,40}, result_ready=1:
  - rd_addr 0..3 on cycles k+1..k+4.
  - result_valid at k+7 with result=300; busy low at k+8.
- len=0:
  - no rd_en pulse.
  - result_valid at k+1 with result=0.
- len=16, all act=wt=255:
  - result=1,040,400 (0x0FE010), no overflow.
- len=20 (greater than N_INPUTS):
  - exactly 16 reads, addresses 0..15.
  - result equals the 16-term sum.
- Backpressure:
  - hold result_ready=0 for 5 cycles after result_valid.
  - result and result_valid stay stable.
  - pulse start during the hold: ignored, no rd_en.
  - raise ready: accept, then IDLE.
- Reset mid-run:
  - assert rst on the third FETCH cycle of a len=8 run.
  - next cycle all outputs are 0 and state is IDLE.
  - a following len=2 run with act={5,6}, wt={7,8} gives result=83, with no residue from the aborted run.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared types and default sizes for the neuron tile
package nn_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} mac_state_t;
    localparam int N_INPUTS_DEF = 16;
    localparam int ACC_W_DEF = 24;
    localparam int DATA_W = 8;
endpackage

// File: rtl/deep.sv
// deep: shared 8x8 unsigned combinational multiplier
module deep
    import nn_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] p
);
    assign p = a * b;
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequences the deep multiplier over memory pairs and accumulates a dot product
module neuron_mac_seq
    import nn_pkg::*;
#(
    parameter int N_INPUTS = N_INPUTS_DEF,
    parameter int ADDR_W   = 4,
    parameter int LEN_W    = 5,
    parameter int ACC_W    = ACC_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] act_data,
    input  logic [DATA_W-1:0] wt_data,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready
);
    mac_state_t state, state_n;
    logic [LEN_W-1:0] len_q, len_sat;
    logic [ADDR_W-1:0] cnt;
    logic dv, prod_v, last_fetch, drain_done, accept_start;
    logic [2*DATA_W-1:0] prod, prod_q;
    logic [ACC_W-1:0] acc;

    deep u_deep (.a(act_data), .b(wt_data), .p(prod));

    assign len_sat = (len > LEN_W'(N_INPUTS)) ? LEN_W'(N_INPUTS) : len;
    assign last_fetch = LEN_W'(cnt) == len_q - LEN_W'(1);
    assign drain_done = cnt == ADDR_W'(1);
    assign accept_start = state == IDLE && start;
    assign busy = state != IDLE;
    assign rd_en = state == FETCH;
    assign rd_addr = cnt;
    assign result_valid = state == DONE;
    assign result = acc;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = (len_sat == '0) ? DONE : FETCH;
            FETCH: if (last_fetch) state_n = DRAIN;
            DRAIN: if (drain_done) state_n = DONE;
            DONE:  if (result_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // cnt walks the read addresses in FETCH, then times the two drain cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            len_q <= '0;
            dv <= 1'b0;
            prod_v <= 1'b0;
            prod_q <= '0;
            acc <= '0;
        end else begin
            dv <= rd_en;
            prod_v <= dv;
            prod_q <= prod;
            if (accept_start) begin
                len_q <= len_sat;
                acc <= '0;
                cnt <= '0;
            end else begin
                if (prod_v) acc <= acc + ACC_W'(prod_q);
                cnt <= (state == FETCH && last_fetch) ? '0 :
                       (state == FETCH || state == DRAIN) ? cnt + ADDR_W'(1) : cnt;
            end
        end
    end
endmodule
